// File: rtl/eth_rx_frame_packer_if.sv
// ----------------------------------------------------------------------------
// eth_rx_frame_packer_if
//   Bundles the MAC-side byte stream and the host-side word/frame handshake
//   of the receive frame packer.
//
//   Parameter:
//     ADDR_W      word-address width of the frame buffer
//   Signals:
//     rx_valid, rx_data[7:0], rx_last, rx_err   MAC -> packer byte stream
//     rx_ready                                  packer -> MAC
//     rd_en, rd_addr[ADDR_W-1:0], frame_ack     host -> packer
//     rd_data[31:0], frame_valid, frame_len[ADDR_W+2:0], frame_err, overflow
//                                               packer -> host
//   Modports:
//     master  the MAC/host side (testbench or surrounding logic)
//     slave   the packer itself
// ----------------------------------------------------------------------------
interface eth_rx_frame_packer_if #(
  parameter int ADDR_W = 9
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_last;
  logic              rx_err;
  logic              rx_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              frame_valid;
  logic [ADDR_W+2:0] frame_len;
  logic              frame_err;
  logic              overflow;
  logic              frame_ack;

  modport master (
    output rx_valid, rx_data, rx_last, rx_err, rd_en, rd_addr, frame_ack,
    input  rx_ready, rd_data, frame_valid, frame_len, frame_err, overflow
  );

  modport slave (
    input  rx_valid, rx_data, rx_last, rx_err, rd_en, rd_addr, frame_ack,
    output rx_ready, rd_data, frame_valid, frame_len, frame_err, overflow
  );
endinterface

// File: rtl/eth_rx_frame_packer.sv
// ----------------------------------------------------------------------------
// eth_rx_frame_packer
//   Receive-side frame buffer. Bytes from the MAC are packed little-endian
//   into 32-bit words and stored in a single-clock word memory. When a frame
//   ends (rx_last) the block stops accepting bytes and holds the frame until
//   the host releases it with frame_ack. The host reads words back with a
//   one-cycle registered read port.
//
//   Parameter:
//     ADDR_W   word-address width; capacity 2^ADDR_W words (4*2^ADDR_W bytes)
//   Ports:
//     clk      single clock for all logic and memory
//     rst_n    asynchronous active-low reset
//     bus      eth_rx_frame_packer_if.slave (byte stream + host handshake)
//
//   Build option:
//     ETH_RX_FCS_STRIP_EN  when defined, frame_len excludes the 4-byte FCS
//                          (bcnt - 4, floored at 0). Memory still holds the
//                          FCS bytes.
// ----------------------------------------------------------------------------
module eth_rx_frame_packer #(
  parameter int ADDR_W = 9
) (
  input logic                  clk,
  input logic                  rst_n,
  eth_rx_frame_packer_if.slave bus
);

  localparam int             BW    = ADDR_W + 3;
  localparam logic [BW-1:0]  CAP   = {1'b1, {(ADDR_W+2){1'b0}}};
  localparam int             DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_RX   = 2'd0;
  localparam logic [1:0] ST_DROP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [BW-1:0]     bcnt;      // bytes stored in the current frame
  logic [31:0]       hold;      // partially packed word
  logic              err;       // sticky frame error
  logic              ovf;       // overflow pulse register
  logic [31:0]       rd_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              at_cap;
  logic              wr_en;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       packed_word;
  logic [BW-1:0]     len_calc;

  assign bus.rx_ready = (state != ST_DONE);

  // NOTE: every signal driven here gets a value before any branch so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept  = bus.rx_valid & bus.rx_ready;
    at_cap  = (bcnt == CAP);
    lane    = bcnt[1:0];
    wr_addr = bcnt[ADDR_W+1:2];
    // Lane 0 starts a fresh word, so lanes not reached before rx_last stay 0.
    packed_word = (lane == 2'd0) ? 32'h0 : hold;
    packed_word[{lane, 3'b000} +: 8] = bus.rx_data;
    wr_en = accept && (state == ST_RX) && !at_cap &&
            ((lane == 2'd3) || bus.rx_last);
  end

`ifdef ETH_RX_FCS_STRIP_EN
  always_comb begin
    len_calc = (bcnt > BW'(4)) ? (bcnt - BW'(4)) : '0;
  end
`else
  always_comb begin
    len_calc = bcnt;
  end
`endif

  assign bus.frame_valid = (state == ST_DONE);
  assign bus.frame_len   = (state == ST_DONE) ? len_calc : '0;
  assign bus.frame_err   = (state == ST_DONE) & err;
  assign bus.overflow    = ovf;
  assign bus.rd_data     = rd_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RX;
      bcnt  <= '0;
      hold  <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      case (state)
        ST_RX: begin
          if (accept) begin
            if (at_cap) begin
              // First byte beyond capacity: drop it, keep bcnt saturated.
              ovf   <= 1'b1;
              err   <= 1'b1;
              state <= bus.rx_last ? ST_DONE : ST_DROP;
            end else begin
              hold <= packed_word;
              bcnt <= bcnt + BW'(1);
              err  <= err | bus.rx_err;
              if (bus.rx_last) state <= ST_DONE;
            end
          end
        end
        ST_DROP: begin
          if (accept) begin
            err <= err | bus.rx_err;
            if (bus.rx_last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.frame_ack) begin
            state <= ST_RX;
            bcnt  <= '0;
            hold  <= '0;
            err   <= 1'b0;
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end

  // NOTE: the word memory has no reset; only its registered read port does.
  // Keeping the array out of the reset block lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= packed_word;
  end

  // Read-first: a same-cycle write to rd_addr is seen on the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 32'h0;
    end else if (bus.rd_en) begin
      rd_q <= mem[bus.rd_addr];
    end
  end

endmodule
